// File: rtl/dapa_pkg.sv
// rtl/dapa_pkg.sv - shared widths and loader state encoding for the program memory
package dapa_pkg;

  // Default instruction word width and word address width.
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  // Loader sequencing: wait for a start, stream words in, pulse completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - program load sequencer: write pointer, length and load status
module prog_mem_loader
  import dapa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_overflow,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  ld_state_t         state;
  ld_state_t         state_d;
  logic [ADDR_W-1:0] wp;
  logic              beat;
  logic              at_end;
  logic              start_take;

  // Status outputs are pure decodes of the state so they are correct straight out of reset.
  always_comb begin
    ld_ready   = (state == LOAD);
    busy       = (state != IDLE);
    ld_done    = (state == DONE);
    beat       = (state == LOAD) && ld_valid;
    at_end     = &wp;
    start_take = (state == IDLE) && ld_start;
    mem_we     = beat;
    mem_waddr  = wp;
    mem_wdata  = ld_data;
  end

  // Next-state: a beat into the last slot ends the load even without ld_last.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (ld_start) state_d = LOAD;
      LOAD: if (beat && (ld_last || at_end)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Write pointer, loaded length and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp          <= '0;
      prog_len    <= '0;
      ld_overflow <= 1'b0;
    end else if (start_take) begin
      wp          <= '0;
      prog_len    <= '0;
      ld_overflow <= 1'b0;
    end else if (beat) begin
      wp       <= wp + 1'b1;
      prog_len <= {1'b0, wp} + LEN_ONE;
      if (at_end && !ld_last) ld_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - loadable instruction memory with a single-cycle fetch port
module prog_mem
  import dapa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              busy,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_overflow,
  output logic [ADDR_W:0]   prog_len
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              fetch_take;
  logic              fetch_hit;

  prog_mem_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk         (clk),
    .reset_n     (reset_n),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .ld_overflow (ld_overflow),
    .prog_len    (prog_len),
    .busy        (busy),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata)
  );

  // A fetch is taken only when idle and not losing to a simultaneous load start;
  // words beyond the loaded length read as zero so stale contents never leak out.
  always_comb begin
    fetch_take = fetch_req && !busy && !ld_start;
    fetch_hit  = ({1'b0, fetch_addr} < prog_len);
  end

  // Storage array is left unreset; prog_len gates its visibility instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Fetch response register: valid pulses one cycle after a taken request, data holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
    end else begin
      fetch_valid <= fetch_take;
      if (fetch_take) fetch_data <= fetch_hit ? mem[fetch_addr] : '0;
    end
  end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning word address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fetch_req  input  1  fetch request.
REQ-006 SHALL have port fetch_addr  input  ADDR_W  fetch word address.
REQ-007 SHALL have port fetch_data  output  DATA_W  fetched instruction word.
REQ-008 SHALL have port fetch_valid  output  1  fetch_data valid, one-cycle pulse.
REQ-009 SHALL have port busy  output  1  load in progress; fetches refused.
REQ-010 SHALL have port ld_start  input  1  begin program load at address 0.
REQ-011 SHALL have port ld_valid  input  1  ld_data beat valid.
REQ-012 SHALL have port ld_data  input  DATA_W  program word.
REQ-013 SHALL have port ld_last  input  1  marks final word of load.
REQ-014 SHALL have port ld_ready  output  1  loader accepts a beat.
REQ-015 SHALL have port ld_done  output  1  one-cycle pulse, load finished.
REQ-016 SHALL have port ld_overflow  output  1  sticky: load exceeded DEPTH.
REQ-017 SHALL have port prog_len  output  ADDR_W+1  number of loaded words.

Function
REQ-018 SHALL implement loader FSM states IDLE, LOAD, DONE.
REQ-019 SHALL, in IDLE with ld_start=1: clear prog_len, wp and ld_overflow, go to LOAD.
REQ-020 SHALL hold ld_ready=1 and busy=1 only in LOAD; busy=1 also in DONE.
REQ-021 SHALL, per LOAD beat (ld_valid&ld_ready): write mem[wp]=ld_data, wp+1, prog_len=wp+1.
REQ-022 SHALL, on beat with ld_last=1, go to DONE; DONE lasts one cycle, asserts ld_done, returns to IDLE.
REQ-023 SHALL, on beat writing wp=DEPTH-1 without ld_last, set ld_overflow and go to DONE; later beats not accepted.
REQ-024 SHALL ignore ld_start in LOAD and DONE.
REQ-025 SHALL, in IDLE, for fetch_req=1 at cycle N, assert fetch_valid at N+1 (latency 1).
REQ-026 SHALL return mem[fetch_addr] when fetch_addr < prog_len, else all-zeros.
REQ-027 SHALL ignore fetch_req while busy=1 (fetch_valid=0 next cycle).
REQ-028 SHALL give ld_start priority over fetch_req in the same IDLE cycle; that fetch is dropped.
REQ-029 SHALL hold fetch_data at its last value when fetch_valid=0.
REQ-030 SHALL support back-to-back fetches, one per cycle, in IDLE.

Reset
REQ-031 SHALL, on reset_n=0, asynchronously force: state IDLE, wp=0, prog_len=0, fetch_valid=0, fetch_data=0, busy=0, ld_ready=0, ld_done=0, ld_overflow=0.
REQ-032 SHALL not reset the storage array; prog_len=0 makes every fetch return 0 after reset.
REQ-033 SHALL, on reset mid-LOAD, discard the load; words already written stay unreachable until reloaded.

Structure
REQ-034 SHALL take DATA_W/ADDR_W defaults and the loader state enum from shared package dapa_pkg.
REQ-035 SHALL place the loader FSM (wp, prog_len, ld_* outputs) in sub-module prog_mem_loader; storage array and fetch path in prog_mem.

Verification
REQ-036 SHALL check reset: after reset_n release, fetch addr 0x00 -> fetch_valid next cycle, fetch_data=0x0000, prog_len=0.
REQ-037 SHALL check load of multiply test program (9 words, ld_last on 9th): ld_done once, prog_len=9; fetch 0x03 -> 0xD101, 0x04 -> 0x3007, 0x08 -> 0xB800, 0x09 -> 0x0000.
REQ-038 SHALL check ld_valid gaps mid-load (3 idle cycles): no duplicate or skipped writes, same contents as REQ-037.
REQ-039 SHALL check overflow (ADDR_W=4, 17 beats, no ld_last): ld_overflow=1, prog_len=16, 17th beat refused, ld_done pulses once.
REQ-040 SHALL check fetch_req during LOAD and in the same cycle as ld_start -> fetch_valid stays 0; busy=1 until cycle after ld_done.
REQ-041 SHALL check reset_n low after 4 of 9 beats -> prog_len=0, state IDLE; fetch 0x02 -> 0x0000.
